lsu_mem_initiator: RTL and testbench

Load/store initiator between the CPU datapath and the word-wide data memory. It accepts byte/half/word loads and stores at byte addresses over a valid/ready request port. It drives the memory's word address, write enable and write data, and returns aligned, extended load data as a one-cycle response pulse. Sub-word stores are done as read-modify-write (RMW), because the memory only writes whole 32-bit words.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_mem_initiator_align.sv | 48 ++++
 rtl/lsu_mem_initiator.sv | 121 ++++++++++++
 tb/tb_lsu_mem_initiator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store initiator.
//   SZ_*            request size encodings (3 is illegal)
//   lsu_state_e     controller states
//   lsu_misaligned  flags illegal size or an address not aligned to size
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   function automatic logic lsu_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_initiator_align.sv
// lsu_lane_align: combinational little-endian lane handling.
//   i_size, i_addr_lo, i_signed  request attributes
//   i_word                       32-bit word read from memory
//   i_wdata                      right-justified store data
//   o_load                       extracted and extended load result
//   o_merge                      i_word with only the addressed lane replaced
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic        i_signed,
   input  logic [31:0] i_word,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load,
   output logic [31:0] o_merge
);

   logic [4:0]  w_bsh;
   logic [4:0]  w_hsh;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_bsh  = {i_addr_lo, 3'b000};
      w_hsh  = {i_addr_lo[1], 4'b0000};
      w_byte = i_word[w_bsh +: 8];
      w_half = i_word[w_hsh +: 16];

      o_load  = i_word;
      o_merge = i_word;
      case (i_size)
         SZ_BYTE: begin
            o_load                = {{24{i_signed & w_byte[7]}}, w_byte};
            o_merge[w_bsh +: 8]   = i_wdata[7:0];
         end
         SZ_HALF: begin
            o_load                = {{16{i_signed & w_half[15]}}, w_half};
            o_merge[w_hsh +: 16]  = i_wdata[15:0];
         end
         default: begin
            o_load  = i_word;
            o_merge = i_wdata;
         end
      endcase
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: byte/half/word load-store initiator for a word-wide
// memory that latches address/data on negedge. Sub-word stores are RMW.
//   clk, reset                 clock, synchronous active-high reset
//   req_*                      valid/ready request port (byte address)
//   resp_valid/rdata/error     one-cycle completion pulse, no backpressure
//   mem_address/writeEnable/dataIn/dataOut   memory word port
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_error,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_writeEnable,
   output logic [31:0]           mem_dataIn,
   input  logic [31:0]           mem_dataOut
);

   lsu_state_e            r_state, w_state_nxt;
   logic                  r_write;
   logic [1:0]            r_size;
   logic                  r_signed;
   logic [1:0]            r_addr_lo;
   logic [31:0]           r_wdata;
   logic                  r_err;
   logic [31:0]           r_rdata;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [31:0]           r_mem_dataIn;

   logic                  w_accept;
   logic                  w_mis;
   logic [31:0]           w_load;
   logic [31:0]           w_merge;

   assign w_mis    = lsu_misaligned(req_size, req_addr[1:0]);
   assign w_accept = req_valid && req_ready;

   // Extraction/merge work on the latched request and the word returned
   // for the RD cycle.
   lsu_lane_align u_align (
      .i_size    (r_size),
      .i_addr_lo (r_addr_lo),
      .i_signed  (r_signed),
      .i_word    (mem_dataOut),
      .i_wdata   (r_wdata),
      .o_load    (w_load),
      .o_merge   (w_merge)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_write       <= 1'b0;
         r_size        <= SZ_BYTE;
         r_signed      <= 1'b0;
         r_addr_lo     <= 2'b00;
         r_wdata       <= '0;
         r_err         <= 1'b0;
         r_rdata       <= '0;
         r_mem_address <= '0;
         r_mem_dataIn  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_write       <= req_write;
            r_size        <= req_size;
            r_signed      <= req_signed;
            r_addr_lo     <= req_addr[1:0];
            r_wdata       <= req_wdata;
            r_err         <= w_mis;
            r_rdata       <= '0;
            r_mem_address <= {2'b00, req_addr[ADDR_WIDTH-1:2]};
            // Word stores write this directly; RMW overwrites it after RD.
            if (req_write) r_mem_dataIn <= req_wdata;
         end
         if (r_state == RD) begin
            if (r_write) r_mem_dataIn <= w_merge;
            else         r_rdata      <= w_load;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_mis)                              w_state_nxt = RESP;
               else if (req_write && req_size == SZ_WORD) w_state_nxt = WR;
               else                                    w_state_nxt = RD;
            end
         end
         RD:      w_state_nxt = r_write ? WR : RESP;
         WR:      w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign req_ready       = (r_state == IDLE) && !reset;
   // A write presented this cycle still lands even if reset is rising.
   assign mem_writeEnable = (r_state == WR);
   // Reset in the RESP cycle suppresses the pulse.
   assign resp_valid      = (r_state == RESP) && !reset;
   assign resp_error      = resp_valid && r_err;
   assign resp_rdata      = r_rdata;
   assign mem_address     = r_mem_address;
   assign mem_dataIn      = r_mem_dataIn;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic [31:0] mem_address;
   logic        mem_writeEnable;
   logic [31:0] mem_dataIn, mem_dataOut;

   lsu_mem_initiator #(.ADDR_WIDTH(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_size        (req_size),
      .req_signed      (req_signed),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_error      (resp_error),
      .mem_address     (mem_address),
      .mem_writeEnable (mem_writeEnable),
      .mem_dataIn      (mem_dataIn),
      .mem_dataOut     (mem_dataOut)
   );

   always #5 clk = ~clk;

   // Memory: writes and registers read data on negedge, read-old-on-write.
   logic [31:0] mem [0:255];
   always @(negedge clk) begin
      if (mem_writeEnable) mem[mem_address[7:0]] <= mem_dataIn;
      mem_dataOut <= mem[mem_address[7:0]];
   end

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          acc;
      int          lat;
      int          we_lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0, n_fail = 0;
   int   cyc = 0, we_cnt = 0, we_cyc = 0, resp_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (mem_writeEnable === 1'b1) begin
         we_cnt++;
         we_cyc = cyc;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (resp_valid === 1'b1) begin
         resp_cnt++;
         if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("resp_error", 32'(resp_error), 32'(e.err));
            chk("resp_rdata", resp_rdata, e.data);
            chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            if (e.we_lat < 0) chk("no_write", 32'(we_cnt), 32'd0);
            else begin
               chk("write_count", 32'(we_cnt), 32'd1);
               chk("write_latency", 32'(we_cyc - e.acc), 32'(e.we_lat));
            end
         end
      end
   end

   // Drive a request; push the expected response at the acceptance edge.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_data,
                        input int lat, input int we_lat, input logic keep);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      for (int n = 0; ; n++) begin
         if (req_ready) begin
            sb.push_back('{err: e_err, data: e_data, acc: cyc + 1, lat: lat, we_lat: we_lat});
            we_cnt = 0;
            @(posedge clk); #1;
            break;
         end
         if (n > 40) begin
            chk("accept_timeout", 32'd0, 32'd1);
            break;
         end
         @(posedge clk); #1;
      end
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; ; n++) begin
         if (sb.size() == 0 && req_ready) break;
         if (n > 40) begin
            chk("idle_timeout", 32'd0, 32'd1);
            sb.delete();
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rc;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_error", 32'(resp_error), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_we", 32'(mem_writeEnable), 32'd0);
      chk("rst_mem_addr", mem_address, 32'd0);
      chk("rst_mem_din", mem_dataIn, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

      // Word store then word load.
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1, 0, 1'b0);
      chk("st_mem_addr", mem_address, 32'h40);
      chk("st_mem_we", 32'(mem_writeEnable), 32'd1);
      chk("st_mem_din", mem_dataIn, 32'hDEADBEEF);
      wait_idle();
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 1, -1, 1'b0);
      wait_idle();

      // Sub-word loads with extension.
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF7F01, 1'b0, 32'h0, 1, 0, 1'b0);
      wait_idle();
      issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b0, 32'hFFFFFF80, 1, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 1'b0, 32'h0000007F, 1, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b0, 32'h00000080, 1, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b0, 32'hFFFF80FF, 1, -1, 1'b0);
      wait_idle();

      // Half-store RMW; upper wdata bits must be ignored.
      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 1'b0, 32'h0, 1, 0, 1'b0);
      wait_idle();
      issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h5555ABCD, 1'b0, 32'h0, 2, 1, 1'b0);
      wait_idle();
      chk("rmw_half_mem", mem[64], 32'hABCD3344);

      // Errors: misaligned word, illegal size, odd half, misaligned word store.
      issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 0, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 0, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 1'b1, 32'h0, 0, -1, 1'b0);
      wait_idle();
      issue(1'b1, 2'd2, 1'b0, 32'h101, 32'h12345678, 1'b1, 32'h0, 0, -1, 1'b0);
      wait_idle();
      chk("err_mem_intact", mem[64], 32'hABCD3344);

      // Every byte lane via RMW, then assemble.
      for (int k = 0; k < 4; k++) begin
         issue(1'b1, 2'd0, 1'b0, 32'h104 + 32'(k), 32'hFFFFFFA0 + 32'(k),
               1'b0, 32'h0, 2, 1, 1'b0);
         wait_idle();
      end
      issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1'b0, 32'hA3A2A1A0, 1, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 1'b0, 32'h0000A3A2, 1, -1, 1'b0);
      wait_idle();
      issue(1'b0, 2'd1, 1'b1, 32'h104, 32'h0, 1'b0, 32'hFFFFA1A0, 1, -1, 1'b0);
      wait_idle();

      // Reset during RD of a byte store: no response, no write.
      rc = resp_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h100; req_wdata = 32'h77;
      we_cnt = 0;
      @(posedge clk); #1;
      chk("abort_in_rd_busy", 32'(req_ready), 32'd0);
      reset = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_no_resp", 32'(resp_cnt - rc), 32'd0);
      chk("abort_no_write", 32'(we_cnt), 32'd0);
      chk("abort_mem", mem[64], 32'hABCD3344);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, 32'hABCD3344, 1, -1, 1'b0);
      wait_idle();

      // Back-to-back with req_valid held high.
      rc = resp_cnt;
      issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1'b0, 32'hA3A2A1A0, 1, -1, 1'b1);
      chk("busy_ready", 32'(req_ready), 32'd0);
      issue(1'b1, 2'd0, 1'b0, 32'h105, 32'h5A, 1'b0, 32'h0, 2, 1, 1'b1);
      chk("busy_ready_rmw", 32'(req_ready), 32'd0);
      issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 1'b0, 32'hA3A25AA0, 1, -1, 1'b0);
      wait_idle();
      chk("queued_resp_count", 32'(resp_cnt - rc), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
